// File: rtl/pwm_duty_gen_if.sv
// Key-pulse / enable / PWM signal bundle between the key debounce stage and pwm_duty_gen.
`timescale 1ns/1ps
interface pwm_duty_gen_if;
  logic       key_up_flag;
  logic       key_down_flag;
  logic       pwm_en;
  logic       pwm_out;
  logic [3:0] duty_level;
  logic       period_end;

  modport master (
    output key_up_flag, key_down_flag, pwm_en,
    input  pwm_out, duty_level, period_end
  );

  modport slave (
    input  key_up_flag, key_down_flag, pwm_en,
    output pwm_out, duty_level, period_end
  );
endinterface

// File: rtl/pwm_duty_gen.sv
// Fixed-frequency PWM with key-stepped duty; duty changes are applied only at period boundaries.
// Define PWM_LEVEL_WRAP_EN to make the level wrap (max->0, 0->max) instead of saturating.
`timescale 1ns/1ps
module pwm_duty_gen #(
  parameter logic [15:0] CNT_PERIOD = 16'd49_999,
  parameter logic [3:0]  STEP_MAX   = 4'd10,
  parameter logic [15:0] DUTY_STEP  = 16'd5_000,
  parameter logic [3:0]  INIT_LEVEL = 4'd5
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  pwm_duty_gen_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned CMP_W = 17;
  localparam int unsigned LVL_W = 4;

  // Compare is one bit wider than the counter so the top level can equal CNT_PERIOD+1.
  localparam logic [CMP_W-1:0] STEP_CMP = CMP_W'(DUTY_STEP);
  localparam logic [CMP_W-1:0] FULL_CMP = CMP_W'(CNT_PERIOD) + CMP_W'(1);
  localparam logic [CMP_W-1:0] INIT_CMP = CMP_W'(INIT_LEVEL) * STEP_CMP;

  logic [CNT_W-1:0] cnt;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_nxt;
  logic [CMP_W-1:0] shadow;
  logic [CMP_W-1:0] shadow_nxt;
  logic [CMP_W-1:0] active;
  logic             pwm_q;
  logic             pend_q;
  logic             up_only;
  logic             down_only;
  logic             last;

  assign up_only   = bus.key_up_flag & ~bus.key_down_flag;
  assign down_only = bus.key_down_flag & ~bus.key_up_flag;
  assign last      = (cnt == CNT_PERIOD);

  // Shadow level/compare update from key pulses, independent of pwm_en.
  always_comb begin
    level_nxt  = level;
    shadow_nxt = shadow;
    if (up_only) begin
      if (level < STEP_MAX) begin
        level_nxt  = level + LVL_W'(1);
        shadow_nxt = shadow + STEP_CMP;
      end
`ifdef PWM_LEVEL_WRAP_EN
      else begin
        level_nxt  = '0;
        shadow_nxt = '0;
      end
`endif
    end else if (down_only) begin
      if (level > LVL_W'(0)) begin
        level_nxt  = level - LVL_W'(1);
        shadow_nxt = shadow - STEP_CMP;
      end
`ifdef PWM_LEVEL_WRAP_EN
      else begin
        level_nxt  = STEP_MAX;
        shadow_nxt = FULL_CMP;
      end
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt    <= '0;
      level  <= INIT_LEVEL;
      shadow <= INIT_CMP;
      active <= INIT_CMP;
      pwm_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      level  <= level_nxt;
      shadow <= shadow_nxt;
      pwm_q  <= bus.pwm_en && ({1'b0, cnt} < active);
      pend_q <= bus.pwm_en && last;
      if (!bus.pwm_en || last) begin
        cnt    <= '0;
        active <= shadow;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pwm_out    = pwm_q;
  assign bus.duty_level = level;
  assign bus.period_end = pend_q;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Directed bench for pwm_duty_gen with a 10-clock period, 5 levels of 2 clocks, initial level 2.
`timescale 1ns/1ps
module tb_pwm_duty_gen;

  logic sys_clk;
  logic sys_rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  localparam logic [9:0] ALL  = 10'b11_1111_1111;
  localparam logic [9:0] NONE = 10'b00_0000_0000;
  localparam logic [9:0] P4   = 10'b00_0000_1111;
  localparam logic [9:0] P6   = 10'b00_0011_1111;
  localparam logic [9:0] PE   = 10'b10_0000_0000;

  pwm_duty_gen_if bus ();

  pwm_duty_gen #(
    .CNT_PERIOD(16'd9),
    .STEP_MAX  (4'd5),
    .DUTY_STEP (16'd2),
    .INIT_LEVEL(4'd2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs n clocks; bit i of each mask drives its input for clock i, outputs sampled 1ns after each edge.
  task automatic run_win(input int n, input logic [9:0] en_m, input logic [9:0] up_m,
                         input logic [9:0] dn_m, output logic [9:0] pw, output logic [9:0] pe,
                         output logic [39:0] lt);
    pw = '0;
    pe = '0;
    lt = '0;
    for (int i = 0; i < n; i++) begin
      bus.pwm_en        = en_m[i];
      bus.key_up_flag   = up_m[i];
      bus.key_down_flag = dn_m[i];
      @(posedge sys_clk);
      #1;
      pw[i]         = bus.pwm_out;
      pe[i]         = bus.period_end;
      lt[i*4 +: 4]  = bus.duty_level;
    end
    bus.key_up_flag   = 1'b0;
    bus.key_down_flag = 1'b0;
  endtask

  task automatic win(input string tag, input logic [9:0] en_m, input logic [9:0] up_m,
                     input logic [9:0] dn_m, input logic [9:0] exp_pw, input logic [9:0] exp_pe,
                     input logic [3:0] exp_lvl, output logic [39:0] lt);
    logic [9:0] pw;
    logic [9:0] pe;
    run_win(10, en_m, up_m, dn_m, pw, pe, lt);
    check({tag, ".pwm"}, 32'(pw), 32'(exp_pw));
    check({tag, ".pend"}, 32'(pe), 32'(exp_pe));
    check({tag, ".level"}, 32'(bus.duty_level), 32'(exp_lvl));
  endtask

  initial begin
    logic [39:0] lt;
    logic [9:0]  pw;
    logic [9:0]  pe;
    logic [3:0]  lvl6;
    logic [9:0]  rst_up;
    logic [9:0]  rst_dn;
    logic [9:0]  rst_pw;

`ifdef PWM_LEVEL_WRAP_EN
    lvl6   = 4'd0;
    rst_up = 10'b00_0000_0101;
    rst_dn = NONE;
    rst_pw = NONE;
`else
    lvl6   = 4'd5;
    rst_up = NONE;
    rst_dn = 10'b00_0001_0101;
    rst_pw = ALL;
`endif

    sys_rst_n         = 1'b0;
    bus.pwm_en        = 1'b1;
    bus.key_up_flag   = 1'b0;
    bus.key_down_flag = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset.pwm", 32'(bus.pwm_out), 32'd0);
    check("reset.pend", 32'(bus.period_end), 32'd0);
    check("reset.level", 32'(bus.duty_level), 32'd2);
    sys_rst_n = 1'b1;

    // Steady 4/10 pattern at the initial level.
    win("s1a", ALL, NONE, NONE, P4, PE, 4'd2, lt);
    win("s1b", ALL, NONE, NONE, P4, PE, 4'd2, lt);

    // Up at cnt=3: level moves next clock, duty only changes next period.
    win("s2a", ALL, 10'b00_0000_1000, NONE, P4, PE, 4'd3, lt);
    check("s2a.lvl_before", 32'(lt[11:8]), 32'd2);
    check("s2a.lvl_after", 32'(lt[15:12]), 32'd3);
    win("s2b", ALL, NONE, NONE, P6, PE, 4'd3, lt);

    // Saturate low, then climb to full scale.
    win("s3a", ALL, NONE, 10'b01_0101_0101, P6, PE, 4'd0, lt);
    win("s3b", ALL, NONE, NONE, NONE, PE, 4'd0, lt);
    win("s3c", ALL, 10'b01_0101_0101, NONE, NONE, PE, 4'd5, lt);
    win("s3d", ALL, NONE, NONE, ALL, PE, 4'd5, lt);
    win("s3e", ALL, NONE, NONE, ALL, PE, 4'd5, lt);
    win("s3f", ALL, 10'b00_0000_0001, NONE, ALL, PE, lvl6, lt);
    win("s3g", ALL, rst_up, rst_dn, rst_pw, PE, 4'd2, lt);

    // Simultaneous up and down is ignored.
    win("s4a", ALL, 10'b00_0000_1000, 10'b00_0000_1000, P4, PE, 4'd2, lt);
    win("s4b", ALL, NONE, NONE, P4, PE, 4'd2, lt);

    // Disable at cnt=2, key while disabled, re-enable from cnt=0 with new duty.
    win("s5a", 10'b00_0000_0011, 10'b00_0010_0000, NONE, 10'b00_0000_0011, NONE, 4'd3, lt);
    check("s5a.lvl_dis", 32'(lt[23:20]), 32'd3);
    win("s5b", ALL, NONE, NONE, P6, PE, 4'd3, lt);

    // Reach level 4, reset asynchronously at cnt=7, resume default pattern.
    win("s6a", ALL, 10'b00_0000_0001, NONE, P6, PE, 4'd4, lt);
    run_win(7, ALL, NONE, NONE, pw, pe, lt);
    check("s6b.pwm", 32'(pw), 32'(10'b00_0111_1111));
    check("s6b.pend", 32'(pe), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    check("s6.async_pwm", 32'(bus.pwm_out), 32'd0);
    check("s6.async_pend", 32'(bus.period_end), 32'd0);
    check("s6.async_level", 32'(bus.duty_level), 32'd2);
    @(posedge sys_clk);
    #1;
    check("s6.hold_pwm", 32'(bus.pwm_out), 32'd0);
    sys_rst_n = 1'b1;
    win("s6c", ALL, NONE, NONE, P4, PE, 4'd2, lt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pwm_duty_gen.md
Name: pwm_duty_gen

Overview:
- Consumes the one-cycle debounced key pulses produced by two key_filter instances (duty up / duty down) plus the toggling enable level, and generates a fixed-frequency PWM output with stepwise-adjustable duty cycle.
- Sits directly downstream of the key debounce stage and drives the LED/PWM pin.
- Duty changes are shadowed and applied only at period boundaries, so no glitch or runt pulse occurs.

Parameters:
- CNT_PERIOD, 16'd49_999: period counter terminal value; period = CNT_PERIOD+1 clocks (1 kHz at 50 MHz).
- STEP_MAX, 4'd10: highest duty level; levels run 0..STEP_MAX.
- DUTY_STEP, 16'd5_000: compare increment per level. Required: STEP_MAX*DUTY_STEP == CNT_PERIOD+1.
- INIT_LEVEL, 4'd5: duty level after reset.

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- sys_rst_n, input, 1: asynchronous active-low reset.
- key_up_flag, input, 1: one-cycle pulse; raise duty by one level.
- key_down_flag, input, 1: one-cycle pulse; lower duty by one level.
- pwm_en, input, 1: level; 1 = PWM running, 0 = output forced low.
- pwm_out, output, 1: registered PWM output.
- duty_level, output, 4: current shadow duty level, 0..STEP_MAX.
- period_end, output, 1: one-cycle pulse on the last clock of each running period.

Behaviour:
- Reset values (async, sys_rst_n low):
  - cnt = 0, pwm_out = 0, period_end = 0.
  - duty_level = INIT_LEVEL.
  - shadow compare and active compare = INIT_LEVEL*DUTY_STEP.
- Compare widths: shadow and active compare registers are 17 bits so they can hold CNT_PERIOD+1.
- Level update (every clock, independent of pwm_en):
  - up only and level < STEP_MAX: level +1, shadow += DUTY_STEP.
  - down only and level > 0: level -1, shadow -= DUTY_STEP.
  - up at STEP_MAX, or down at 0: no change (saturate).
  - up and down in the same cycle: no change.
  - duty_level reflects the new value the cycle after the flag.
- Period counter:
  - pwm_en = 1: cnt counts 0..CNT_PERIOD and wraps to 0.
  - pwm_en = 0: cnt is held at 0.
- Shadow-to-active load:
  - active compare <= shadow when cnt == CNT_PERIOD with pwm_en = 1, or on any cycle with pwm_en = 0.
  - A flag arriving on the cnt == CNT_PERIOD cycle itself takes effect one period later, because shadow updates in that same clock.
- pwm_out registered: pwm_out(t+1) = pwm_en(t) && (cnt(t) < active(t)).
  - Level 0: output constantly low.
  - Level STEP_MAX: active = CNT_PERIOD+1, output constantly high with no gap at wrap.
- period_end(t+1) = pwm_en(t) && cnt(t) == CNT_PERIOD.
- pwm_en falling mid-period:
  - pwm_out goes low on the next clock and cnt goes to 0 on the same clock.
  - On re-enable, the period restarts at cnt = 0 with the current shadow duty.
- Reset mid-period: all state returns to reset values immediately; no partial period completes.

Optional Feature:
- Macro: PWM_LEVEL_WRAP_EN.
- Defined:
  - up at STEP_MAX wraps to level 0 (shadow = 0).
  - down at 0 wraps to STEP_MAX (shadow = CNT_PERIOD+1).
  - Simultaneous up and down is still no change.
- Undefined: saturating behaviour as described in Behaviour.

Test Plan:
All scenarios use CNT_PERIOD=9, STEP_MAX=5, DUTY_STEP=2, INIT_LEVEL=2.
1. Release reset with pwm_en=1 and no keys -> pwm_out high for exactly 4 of every 10 clocks; period_end pulses every 10 clocks; duty_level=2.
2. key_up_flag pulse mid-period, at cnt=3 -> duty_level=3 on the next clock; current period keeps 4 high clocks; next period has 6 high clocks with no runt pulse.
3. Five key_down_flag pulses -> level saturates at 0 and pwm_out stays 0. Then five key_up_flag pulses -> level 5 and pwm_out is continuously 1 across the wrap (no low gap). With PWM_LEVEL_WRAP_EN, a sixth up pulse -> level 0.
4. key_up_flag and key_down_flag asserted in the same cycle -> duty_level and pwm_out pattern unchanged.
5. Drop pwm_en at cnt=2 while high -> pwm_out=0 and cnt=0 the next clock; no period_end. Apply key_up_flag while disabled -> level changes. Re-enable -> first period uses the new duty starting from cnt=0.
6. Assert sys_rst_n low at cnt=7 with level 4 -> pwm_out, period_end, cnt = 0 and duty_level=2 asynchronously; after release, a normal 4/10 pattern resumes.
